// File: rtl/print_pkg.sv
// Constants shared by the print arbiter and the print engine: payload width,
// arbiter state encoding, print types and the engine's separator glyphs.
package print_pkg;

  localparam int DATA_W = 32;

  localparam logic TYPE_BYTE = 1'b0;
  localparam logic TYPE_WORD = 1'b1;

  localparam logic [7:0] ASCII_SPACE      = 8'h20;
  localparam logic [7:0] ASCII_DASH       = 8'h2D;
  localparam logic [7:0] ASCII_UNDERSCORE = 8'h5F;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  // Increment with wrap at n, used for the round-robin pointer.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/print_arbiter_if.sv
// Requester-side and print-engine-side signals of the print arbiter.
// master = arbiter view, slave = requesters plus engine.
interface print_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int IDX_W  = 2,
  parameter int DATA_W = 32
);

  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        req_type;
  logic [NREQ*DATA_W-1:0] data;
  logic [NREQ-1:0]        ack;
  logic                   busy;
  logic [IDX_W-1:0]       grant_idx;

  logic                   pr_req;
  logic                   pr_type;
  logic [DATA_W-1:0]      pr_dout;
  logic                   pr_ack;

  modport master (
    input  req, req_type, data, pr_ack,
    output ack, busy, grant_idx, pr_req, pr_type, pr_dout
  );

  modport slave (
    output req, req_type, data, pr_ack,
    input  ack, busy, grant_idx, pr_req, pr_type, pr_dout
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping.
// Rotate down by ptr, find lowest set bit, rotate the index back up.
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             vld,
  output logic [IDX_W-1:0] win
);

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [IDX_W-1:0]  first_set;
  logic [IDX_W:0]    win_sum;

  always_comb begin
    req_dbl   = {req, req};
    req_rot   = NREQ'(req_dbl >> ptr);
    first_set = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_rot[i]) first_set = IDX_W'(i);
    end
    win_sum = {1'b0, first_set} + {1'b0, ptr};
    if (win_sum >= (IDX_W + 1)'(NREQ)) win_sum = win_sum - (IDX_W + 1)'(NREQ);
    vld = |req;
    win = win_sum[IDX_W-1:0];
  end

endmodule

// File: rtl/print_arbiter.sv
// Round-robin arbiter sharing the print engine; pr_req rises one edge after req is seen
// in IDLE and is held indefinitely until pr_ack; then a one-cycle ack and one release cycle.
module print_arbiter
  import print_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int IDX_W  = 2,
  parameter int DATA_W = print_pkg::DATA_W
) (
  input  logic            clk,
  input  logic            rstn,
  print_arbiter_if.master bus
);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  grant_idx_q, grant_idx_d;
  logic              pr_req_q, pr_req_d;
  logic              pr_type_q, pr_type_d;
  logic [DATA_W-1:0] pr_dout_q, pr_dout_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              busy_q, busy_d;

  logic              pick_vld;
  logic [IDX_W-1:0]  pick_win;
  logic [DATA_W-1:0] data_arr [NREQ];

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .vld (pick_vld),
    .win (pick_win)
  );

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      data_arr[i] = bus.data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_idx_d = grant_idx_q;
    pr_req_d    = pr_req_q;
    pr_type_d   = pr_type_q;
    pr_dout_d   = pr_dout_q;
    ack_d       = '0;
    busy_d      = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          pr_dout_d   = data_arr[pick_win];
          pr_type_d   = bus.req_type[pick_win];
          grant_idx_d = pick_win;
          ptr_d       = IDX_W'(wrap_inc(int'(pick_win), NREQ));
          busy_d      = 1'b1;
          pr_req_d    = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      // Payload stays frozen here; requester-side changes are ignored until release.
      ST_ISSUE: begin
        if (bus.pr_ack) begin
          pr_req_d           = 1'b0;
          ack_d[grant_idx_q] = 1'b1;
          state_d            = ST_RELEASE;
        end
      end
      // Extra idle cycle so the engine sees its own ack clear before the next pr_req.
      ST_RELEASE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      grant_idx_q <= '0;
      pr_req_q    <= 1'b0;
      pr_type_q   <= 1'b0;
      pr_dout_q   <= '0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_idx_q <= grant_idx_d;
      pr_req_q    <= pr_req_d;
      pr_type_q   <= pr_type_d;
      pr_dout_q   <= pr_dout_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.busy      = busy_q;
  assign bus.grant_idx = grant_idx_q;
  assign bus.pr_req    = pr_req_q;
  assign bus.pr_type   = pr_type_q;
  assign bus.pr_dout   = pr_dout_q;

endmodule

// File: tb/tb_print_arbiter.sv
// Randomized bench for print_arbiter: a transaction-level predictor queues expected
// grants/acks, a separate monitor compares them against DUT outputs at negedge.
module tb_print_arbiter;
  import print_pkg::*;

  localparam int NREQ  = 4;
  localparam int IDX_W = 2;
  localparam int DW    = 32;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  print_arbiter_if #(.NREQ(NREQ), .IDX_W(IDX_W), .DATA_W(DW)) bus ();

  print_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W), .DATA_W(DW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Stimulus state, driven only by the main initial block
  logic [NREQ-1:0] req_r;
  logic [NREQ-1:0] typ_r;
  logic [DW-1:0]   dat_r [NREQ];
  logic            pr_ack_r;

  assign bus.req      = req_r;
  assign bus.req_type = typ_r;
  assign bus.pr_ack   = pr_ack_r;
  always_comb begin
    for (int i = 0; i < NREQ; i++) bus.data[i*DW +: DW] = dat_r[i];
  end

  int remaining [NREQ];
  int gap       [NREQ];
  bit drop_mid  [NREQ];
  bit owed      [NREQ];
  bit keep_high;
  int gap_max, lat_min, lat_max;
  int eng_cnt;
  bit eng_done;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Expected-event scoreboard
  typedef struct {
    int          e;
    int          idx;
    logic [DW-1:0] d;
    logic        t;
  } exp_t;

  exp_t gq[$];
  exp_t aq[$];
  int   edge_cnt = 0;

  // Reference model: round-robin over pending requests, one transaction at a time,
  // next grant no earlier than two edges after the edge that samples pr_ack.
  int   m_ptr, m_next_free, m_cur, pe, pw;
  bit   m_pend;
  logic [DW-1:0] m_data;

  always @(posedge clk) begin
    edge_cnt++;
    #3;
    if (!rstn) begin
      m_ptr = 0; m_next_free = 0; m_pend = 0;
      gq.delete(); aq.delete();
    end else begin
      pe = edge_cnt + 1;
      if (m_pend && bus.pr_ack) begin
        aq.push_back('{e: pe, idx: m_cur, d: m_data, t: 1'b0});
        m_pend      = 0;
        m_next_free = pe + 2;
      end else if (!m_pend && pe >= m_next_free && bus.req != '0) begin
        pw = -1;
        for (int k = 0; k < NREQ; k++) begin
          if (pw < 0 && bus.req[(m_ptr + k) % NREQ]) pw = (m_ptr + k) % NREQ;
        end
        gq.push_back('{e: pe, idx: pw, d: dat_r[pw], t: typ_r[pw]});
        m_cur  = pw;
        m_data = dat_r[pw];
        m_ptr  = (pw + 1) % NREQ;
        m_pend = 1;
      end
    end
  end

  // Monitor
  bit   prev_req, prev_ack, got_g, exp_g, got_a, exp_a;
  int   low_run;
  int   grant_cnt [NREQ];
  exp_t ent;

  always @(negedge clk) begin
    if (!rstn) begin
      prev_req = 0; prev_ack = 0; low_run = 100;
    end else begin
      got_g = bus.pr_req && !prev_req;
      exp_g = gq.size() > 0 && gq[0].e == edge_cnt;
      if (got_g && exp_g) begin
        ent = gq.pop_front();
        check("grant_idx", 64'(bus.grant_idx), 64'(ent.idx));
        check("grant_dout", 64'(bus.pr_dout), 64'(ent.d));
        check("grant_type", 64'(bus.pr_type), 64'(ent.t));
        check("grant_busy", 64'(bus.busy), 64'(1));
        check("idle_gap_ge2", 64'(low_run >= 2), 64'(1));
        grant_cnt[ent.idx]++;
      end else if (got_g || exp_g) begin
        n_checks++;
        $display("FAIL grant_event: got %0d expected %0d at edge %0d", got_g, exp_g, edge_cnt);
        if (exp_g) void'(gq.pop_front());
      end

      got_a = bus.ack != '0;
      exp_a = aq.size() > 0 && aq[0].e == edge_cnt;
      if (got_a && exp_a) begin
        ent = aq.pop_front();
        check("ack_vec", 64'(bus.ack), 64'(NREQ'(1) << ent.idx));
        check("ack_busy", 64'(bus.busy), 64'(1));
        check("ack_dout_frozen", 64'(bus.pr_dout), 64'(ent.d));
      end else if (got_a || exp_a) begin
        n_checks++;
        $display("FAIL ack_event: got %0h expected %0d at edge %0d", bus.ack, exp_a, edge_cnt);
        if (exp_a) void'(aq.pop_front());
      end

      if (prev_ack) check("post_ack_idle", 64'({bus.busy, bus.ack, bus.pr_req}), 64'(0));

      low_run  = bus.pr_req ? 0 : low_run + 1;
      prev_req = bus.pr_req;
      prev_ack = got_a;
    end
  end

  task automatic raise(input int i);
    req_r[i] = 1'b1;
    dat_r[i] = $urandom;
    typ_r[i] = 1'($urandom_range(1, 0));
  endtask

  // One clock of requester and print-engine behaviour
  task automatic step();
    @(posedge clk);
    #1;
    if (pr_ack_r) begin
      pr_ack_r = 1'b0;
      eng_done = 1;
    end else if (!bus.pr_req) begin
      eng_done = 0;
      eng_cnt  = -1;
    end else if (!eng_done) begin
      if (eng_cnt < 0) eng_cnt = $urandom_range(lat_max, lat_min);
      if (eng_cnt == 0) pr_ack_r = 1'b1;
      else eng_cnt--;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (bus.ack[i]) begin
        owed[i] = 0;
        remaining[i]--;
        if (remaining[i] > 0 && (keep_high || $urandom_range(1, 0) == 1)) raise(i);
        else begin
          req_r[i] = 1'b0;
          gap[i]   = $urandom_range(gap_max, 0);
        end
      end else if (drop_mid[i] && req_r[i] && bus.pr_req && bus.grant_idx == IDX_W'(i)) begin
        req_r[i]    = 1'b0;
        dat_r[i]    = ~dat_r[i];
        drop_mid[i] = 0;
        owed[i]     = 1;
      end else if (!req_r[i] && !owed[i] && remaining[i] > 0) begin
        if (gap[i] == 0) raise(i);
        else gap[i]--;
      end
    end
  endtask

  task automatic run_until_idle(input string name, input int budget);
    int n, quiet, left;
    n = 0; quiet = 0;
    while (quiet < 4 && n < budget) begin
      step();
      n++;
      left = 0;
      for (int i = 0; i < NREQ; i++) left += remaining[i];
      if (left == 0 && req_r == '0 && !bus.busy && !bus.pr_req) quiet++;
      else quiet = 0;
    end
    check({name, "_completes"}, 64'(n < budget), 64'(1));
  endtask

  task automatic clear_reqs();
    req_r = '0;
    for (int i = 0; i < NREQ; i++) begin
      remaining[i] = 0; gap[i] = 0; drop_mid[i] = 0; owed[i] = 0;
    end
  endtask

  int w;

  initial begin
    typ_r = '0; pr_ack_r = 1'b0; keep_high = 0; gap_max = 0;
    lat_min = 0; lat_max = 3; eng_cnt = -1; eng_done = 0;
    for (int i = 0; i < NREQ; i++) begin dat_r[i] = '0; grant_cnt[i] = 0; end
    clear_reqs();

    repeat (3) @(posedge clk);
    #1;
    check("rst_pr_req", 64'(bus.pr_req), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_ack", 64'(bus.ack), 64'(0));
    check("rst_grant_idx", 64'(bus.grant_idx), 64'(0));
    check("rst_pr_dout", 64'(bus.pr_dout), 64'(0));
    check("rst_pr_type", 64'(bus.pr_type), 64'(0));
    rstn = 1'b1;

    // Single byte request from requester 2, slow engine
    lat_min = 20; lat_max = 20;
    req_r[2] = 1'b1; dat_r[2] = 32'h0000_0041; typ_r[2] = TYPE_BYTE; remaining[2] = 1;
    run_until_idle("single", 200);
    check("single_grants_r2", 64'(grant_cnt[2]), 64'(1));

    // Two simultaneous requesters
    lat_min = 0; lat_max = 5;
    raise(0); raise(1); remaining[0] = 1; remaining[1] = 1;
    run_until_idle("pair", 200);

    // All requesters held continuously, three transactions each
    for (int i = 0; i < NREQ; i++) grant_cnt[i] = 0;
    keep_high = 1; lat_min = 10; lat_max = 10;
    for (int i = 0; i < NREQ; i++) begin remaining[i] = 3; raise(i); end
    run_until_idle("saturate", 1000);
    for (int i = 0; i < NREQ; i++) check($sformatf("saturate_grants_r%0d", i), 64'(grant_cnt[i]), 64'(3));
    keep_high = 0;

    // Requester 1 drops req and changes data mid-transaction
    for (int i = 0; i < NREQ; i++) grant_cnt[i] = 0;
    lat_min = 4; lat_max = 8;
    remaining[1] = 1; drop_mid[1] = 1; raise(1);
    run_until_idle("drop_mid", 200);
    check("drop_mid_single_grant", 64'(grant_cnt[1]), 64'(1));

    // Randomized rounds
    lat_min = 0; lat_max = 6; gap_max = 3;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NREQ; i++) begin
        remaining[i] = $urandom_range(4, 0);
        gap[i]       = $urandom_range(3, 0);
      end
      run_until_idle($sformatf("random%0d", r), 3000);
    end
    gap_max = 0;

    // Reset during ISSUE with the engine never answering
    lat_min = 1000; lat_max = 1000;
    remaining[1] = 1; raise(1);
    w = 0;
    while (!bus.pr_req && w < 20) begin step(); w++; end
    check("reset_test_issue_reached", 64'(bus.pr_req), 64'(1));
    step();
    rstn = 1'b0;
    #1;
    check("midrst_pr_req", 64'(bus.pr_req), 64'(0));
    check("midrst_busy", 64'(bus.busy), 64'(0));
    check("midrst_ack", 64'(bus.ack), 64'(0));
    check("midrst_grant_idx", 64'(bus.grant_idx), 64'(0));
    clear_reqs();
    pr_ack_r = 1'b0; eng_cnt = -1; eng_done = 0;
    lat_min = 0; lat_max = 3;
    for (int i = 0; i < NREQ; i++) grant_cnt[i] = 0;
    step();
    rstn = 1'b1;
    raise(0); raise(3); remaining[0] = 1; remaining[3] = 1;
    run_until_idle("after_reset", 200);
    check("after_reset_grants_r0", 64'(grant_cnt[0]), 64'(1));
    check("after_reset_grants_r3", 64'(grant_cnt[3]), 64'(1));

    repeat (3) step();
    check("scoreboard_drained", 64'(gq.size() + aq.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
